// File: rtl/ha_array_row_accumulator_if.sv
// Handshake bundle between the approximate half-adder array and the row accumulator.
// The master drives the row groups and consumes the product; the slave is the accumulator.
interface ha_array_row_accumulator_if;
  logic       in_valid;
  logic       in_ready;
  logic [6:0] ha_array_0_b;
  logic [6:0] ha_array_1_b;
  logic [6:0] ha_array_2_b;
  logic [6:0] ha_array_3_b;
  logic [8:0] ha_array_0_t;
  logic [8:0] ha_array_1_t;
  logic [8:0] ha_array_2_t;
  logic [8:0] ha_array_3_t;
  logic       out_valid;
  logic       out_ready;
  logic [15:0] out_product;
  logic       busy;

  modport master (
    output in_valid, ha_array_0_b, ha_array_1_b, ha_array_2_b, ha_array_3_b,
           ha_array_0_t, ha_array_1_t, ha_array_2_t, ha_array_3_t, out_ready,
    input  in_ready, out_valid, out_product, busy
  );

  modport slave (
    input  in_valid, ha_array_0_b, ha_array_1_b, ha_array_2_b, ha_array_3_b,
           ha_array_0_t, ha_array_1_t, ha_array_2_t, ha_array_3_t, out_ready,
    output in_ready, out_valid, out_product, busy
  );
endinterface

// File: rtl/ha_array_row_accumulator.sv
// Serial final-summation stage for the unsigned 8x8 approximate half-adder array.
// Captures four row groups, adds ROWS_PER_CYCLE of them per clock into a 16-bit
// accumulator and presents the product over a valid/ready pair.
// Optional feature macro: APPROX_BIAS_COMP_EN (seed the accumulator with COMP_BIAS).
// Timing: the transfer cycle is followed by 4/ROWS_PER_CYCLE ACC cycles, so out_valid
// rises in the (4/ROWS_PER_CYCLE + 1)-th cycle after the transfer cycle.
module ha_array_row_accumulator #(
  parameter int          ROWS_PER_CYCLE = 1,
  parameter logic [15:0] COMP_BIAS      = 16'd27
) (
  input  logic clk,
  input  logic rst_n,
  ha_array_row_accumulator_if.slave bus
);

  if (!(ROWS_PER_CYCLE == 1 || ROWS_PER_CYCLE == 2 || ROWS_PER_CYCLE == 4)) begin : g_bad_rpc
    $error("ROWS_PER_CYCLE must be 1, 2 or 4");
  end

`ifdef APPROX_BIAS_COMP_EN
  localparam logic [15:0] ACC_INIT = COMP_BIAS;
`else
  // Bias disabled: seed is a constant zero, COMP_BIAS folds away.
  localparam logic [15:0] ACC_INIT = COMP_BIAS & 16'h0000;
`endif

  localparam logic [1:0] IDX_STEP = 2'(ROWS_PER_CYCLE);
  localparam logic [1:0] IDX_LAST = 2'(4 - ROWS_PER_CYCLE);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_ACC = 2'd1, S_DONE = 2'd2} state_e;

  state_e          state_q, state_d;
  logic [3:0][6:0] b_q;
  logic [3:0][8:0] t_q;
  logic [3:0][6:0] b_in;
  logic [3:0][8:0] t_in;
  logic [15:0]     acc_q, acc_d;
  logic [15:0]     out_product_q;
  logic [1:0]      idx_q;
  logic [3:0][15:0] rows;
  logic            in_ready_c, out_valid_c, busy_c;
  logic            xfer, last_step;

  assign b_in = {bus.ha_array_3_b, bus.ha_array_2_b, bus.ha_array_1_b, bus.ha_array_0_b};
  assign t_in = {bus.ha_array_3_t, bus.ha_array_2_t, bus.ha_array_1_t, bus.ha_array_0_t};

  assign xfer      = bus.in_valid & in_ready_c;
  assign last_step = (idx_q == IDX_LAST);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next-state: DONE hands straight to ACC when a new bundle is waiting.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (bus.in_valid) state_d = S_ACC;
      S_ACC:  if (last_step)    state_d = S_DONE;
      S_DONE: if (bus.out_ready) state_d = bus.in_valid ? S_ACC : S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Handshake outputs; out_ready reaches in_ready combinationally in DONE.
  always_comb begin
    in_ready_c  = 1'b0;
    out_valid_c = 1'b0;
    busy_c      = 1'b0;
    case (state_q)
      S_IDLE: in_ready_c = 1'b1;
      S_ACC:  busy_c     = 1'b1;
      S_DONE: begin
        out_valid_c = 1'b1;
        in_ready_c  = bus.out_ready;
      end
      default: ;
    endcase
  end

  // Weighted row values from the captured bundle: (t + 4b) << 2g.
  always_comb begin
    rows = '0;
    for (int g = 0; g < 4; g++)
      rows[g] = ({7'b0, t_q[g]} + {7'b0, b_q[g], 2'b00}) << (2 * g);
  end

  // Add this cycle's row groups, starting at idx.
  always_comb begin
    acc_d = acc_q;
    for (int j = 0; j < ROWS_PER_CYCLE; j++)
      acc_d = acc_d + rows[idx_q + 2'(j)];
  end

  // Datapath: capture on transfer, accumulate in ACC, publish on the final step.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      b_q           <= '0;
      t_q           <= '0;
      acc_q         <= '0;
      idx_q         <= '0;
      out_product_q <= '0;
    end else if (xfer) begin
      b_q   <= b_in;
      t_q   <= t_in;
      acc_q <= ACC_INIT;
      idx_q <= '0;
    end else if (state_q == S_ACC) begin
      acc_q <= acc_d;
      idx_q <= idx_q + IDX_STEP;
      if (last_step) out_product_q <= acc_d;
    end
  end

  assign bus.in_ready    = in_ready_c;
  assign bus.out_valid   = out_valid_c;
  assign bus.busy        = busy_c;
  assign bus.out_product = out_product_q;

endmodule
